nfc_status_poller: RTL and testbench
====================================

NFC_STATUS_POLLER -- requirements
Module: nfc_status_poller

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4, width of the way-select bus.
REQ-002 SHALL have parameter CommandID, default 6'b000111, opcode of the downstream read-status command block.
REQ-003 SHALL have parameter PollInterval, default 16'd64, idle cycles between consecutive polls.
REQ-004 SHALL have parameter MaxPolls, default 16'd1000, poll limit before timeout.
REQ-005 SHALL use one clock and a synchronous, active-high reset: iSystemClock input 1 (system clock); iReset input 1 (synchronous reset).
REQ-006 SHALL have request ports: iPollValid input 1 (start poll); oPollReady output 1 (idle, can accept); iWaySelect input NumberOfWays (target way, one-hot); iRowAddress input 24 (row for enhanced status); iEnhanced input 1 (1 = 78h, 0 = 70h).
REQ-007 SHALL have command-side ports: oOpcode output 6; oTargetID output 5; oCMDValid output 1; iCMDReady input 1; oWaySelect output NumberOfWays; oRowAddress output 24.
REQ-008 SHALL have status-side ports: iStatus input 24 (status word, byte in [7:0]); iStatusValid input 1; iLastStep input 1 (downstream command finished).
REQ-009 SHALL have result ports: oDone output 1 (one-cycle completion pulse); oFail output 1 (status bit0 at completion); oTimeout output 1 (limit reached); oFinalStatus output 8 (last status byte); oPollCount output 16 (polls issued).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK, INTERVAL, DONE.
REQ-011 IDLE: oPollReady=1; iPollValid=1 SHALL latch the way, row and enhanced inputs, clear the poll count, and go to ISSUE.
REQ-012 ISSUE: SHALL drive oCMDValid=1, oOpcode=CommandID and oTargetID={4'b0,enhanced}, with latched way and row; oCMDValid SHALL hold until iCMDReady=1 in the same cycle, then SHALL go to WAIT with the poll count +1.
REQ-013 WAIT: iStatusValid=1 SHALL capture iStatus[7:0]; iLastStep=1 SHALL go to CHECK; if both arrive in the same cycle, SHALL capture and transition.
REQ-014 CHECK: status bit6 (RDY)=1 SHALL go to DONE; otherwise SHALL go to INTERVAL with the interval counter loaded with PollInterval-1.
REQ-015 INTERVAL: SHALL decrement the counter each cycle and go to ISSUE when it is 0; PollInterval=0 or 1 SHALL give 1 cycle.
REQ-016 DONE: SHALL pulse oDone for exactly 1 cycle, set oFail=captured bit0 and oFinalStatus=captured byte, then return to IDLE; oFail, oFinalStatus and oTimeout SHALL hold until the next accepted request.
REQ-017 Request-to-first-oCMDValid latency SHALL be 1 cycle; iLastStep-to-oDone SHALL be 2 cycles when RDY=1.
REQ-018 iPollValid outside IDLE SHALL be ignored.
REQ-019 iStatusValid outside WAIT SHALL be ignored.
REQ-020 oPollCount SHALL saturate at 16'hFFFF.

Reset
REQ-021 iReset SHALL force IDLE at any state, including mid-poll.
REQ-022 On reset: oPollReady=1; oCMDValid=0; oOpcode=0; oTargetID=0; oWaySelect=0; oRowAddress=0; oDone=0; oFail=0; oTimeout=0; oFinalStatus=0; oPollCount=0.

Configuration
REQ-023 With NFC_POLL_TIMEOUT_EN defined: in CHECK with RDY=0 and poll count ≥ MaxPolls, SHALL go to DONE with oTimeout=1 and oFail=1.
REQ-024 Without NFC_POLL_TIMEOUT_EN: SHALL poll indefinitely, oTimeout SHALL be tied 0, and MaxPolls SHALL be unused.

Structure
REQ-025 Shared package nfc_poll_pkg SHALL hold the state encoding, the status bit positions (RDY=6, FAIL=0) and the default CommandID.
REQ-026 Sub-module nfc_poll_timer SHALL hold the loadable down-counter with a zero flag for INTERVAL.

Verification
REQ-027 Poll with iEnhanced=0, way 4'b0010, first status 8'hE0 -> exactly 1 command (oTargetID=0, oWaySelect=4'b0010); oDone 2 cycles after iLastStep; oFail=0; oFinalStatus=8'hE0; oPollCount=1.
REQ-028 Statuses 8'h80, 8'h80, 8'hC1 with PollInterval=8 -> 3 commands ≥8 idle cycles apart; oFail=1; oFinalStatus=8'hC1; oPollCount=3.
REQ-029 iCMDReady held 0 for 5 cycles -> oCMDValid stays high and opcode, target, way and row stay stable; exactly one acceptance.
REQ-030 NFC_POLL_TIMEOUT_EN defined, MaxPolls=3, status always 8'h80 -> oDone after the 3rd poll; oTimeout=1; oFail=1; no 4th command.
REQ-031 iStatusValid and iLastStep in the same cycle with 8'h40 -> captured; oDone 2 cycles later.
REQ-032 iReset asserted in WAIT, then a new request -> all outputs at reset values; new poll behaves as REQ-027.

Source files
------------

// File: rtl/nfc_poll_pkg.sv
// ---------------------------------------------------------------------------
// nfc_poll_pkg
// Shared definitions for the NFC status poller.
// Contents:
//   poll_state_e     - FSM state encoding
//   StatusRdyBit     - ready bit position in the NAND status byte
//   StatusFailBit    - fail bit position in the NAND status byte
//   DefaultCommandId - opcode of the downstream read-status command block
//   interval_load()  - reload value for the inter-poll wait counter
// ---------------------------------------------------------------------------
package nfc_poll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_INTERVAL = 3'd4,
    ST_DONE     = 3'd5
  } poll_state_e;

  localparam int unsigned StatusRdyBit  = 6;
  localparam int unsigned StatusFailBit = 0;

  localparam logic [5:0] DefaultCommandId = 6'b000111;

  // The counter runs from the load value down to zero inclusive, so a load
  // of N-1 gives N wait cycles. Intervals of 0 and 1 both collapse to one.
  function automatic logic [15:0] interval_load(input logic [15:0] interval);
    return (interval == 16'd0) ? 16'd0 : interval - 16'd1;
  endfunction

endpackage

// File: rtl/nfc_status_poller_if.sv
// ---------------------------------------------------------------------------
// nfc_status_poller_if
// Command-side handshake between the status poller and the downstream
// command block.
// Signals:
//   oOpcode     - command opcode
//   oTargetID   - target ID ({4'b0, enhanced})
//   oCMDValid   - command valid
//   iCMDReady   - command accepted by downstream block
//   oWaySelect  - one-hot way select
//   oRowAddress - row address for enhanced status
// Modports: master (poller side), slave (command block side).
// ---------------------------------------------------------------------------
interface nfc_status_poller_if #(
  parameter int NumberOfWays = 4
);
  logic [5:0]              oOpcode;
  logic [4:0]              oTargetID;
  logic                    oCMDValid;
  logic                    iCMDReady;
  logic [NumberOfWays-1:0] oWaySelect;
  logic [23:0]             oRowAddress;

  modport master (
    output oOpcode, oTargetID, oCMDValid, oWaySelect, oRowAddress,
    input  iCMDReady
  );

  modport slave (
    input  oOpcode, oTargetID, oCMDValid, oWaySelect, oRowAddress,
    output iCMDReady
  );
endinterface

// File: rtl/nfc_poll_timer.sv
// ---------------------------------------------------------------------------
// nfc_poll_timer
// Loadable down-counter with a zero flag, used to pace polls.
// Ports:
//   clk_i        - clock
//   srst_i       - synchronous active-high reset
//   load_i       - load load_value_i (has priority over dec_i)
//   load_value_i - value to load
//   dec_i        - decrement by one; holds at zero
//   zero_o       - counter is zero
// ---------------------------------------------------------------------------
module nfc_poll_timer #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/nfc_status_poller.sv
// ---------------------------------------------------------------------------
// nfc_status_poller
// Repeatedly issues a read-status command (70h / 78h) to one NAND way until
// the ready bit is set, waiting PollInterval cycles between polls.
// Optional feature macro: NFC_POLL_TIMEOUT_EN - give up after MaxPolls polls
// with oTimeout=1 and oFail=1. Without it the poller retries forever and
// oTimeout is tied low.
// Ports:
//   iSystemClock, iReset       - clock, synchronous active-high reset
//   iPollValid / oPollReady    - request handshake (accepted only when idle)
//   iWaySelect, iRowAddress,
//   iEnhanced                  - request parameters, latched on acceptance
//   cmd_if (master)            - command handshake to the command block
//   iStatus, iStatusValid,
//   iLastStep                  - status word / command completion
//   oDone, oFail, oTimeout,
//   oFinalStatus, oPollCount   - result; held until the next request
// ---------------------------------------------------------------------------
module nfc_status_poller
  import nfc_poll_pkg::*;
#(
  parameter int          NumberOfWays = 4,
  parameter logic [5:0]  CommandID    = DefaultCommandId,
  parameter logic [15:0] PollInterval = 16'd64,
  parameter logic [15:0] MaxPolls     = 16'd1000
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic                    iPollValid,
  output logic                    oPollReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  input  logic [23:0]             iRowAddress,
  input  logic                    iEnhanced,
  nfc_status_poller_if.master     cmd_if,
  input  logic [23:0]             iStatus,
  input  logic                    iStatusValid,
  input  logic                    iLastStep,
  output logic                    oDone,
  output logic                    oFail,
  output logic                    oTimeout,
  output logic [7:0]              oFinalStatus,
  output logic [15:0]             oPollCount
);

  localparam logic [15:0] IntervalLoad = interval_load(PollInterval);

  poll_state_e             state_q;
  logic                    ready_q;
  logic                    cmd_valid_q;
  logic [5:0]              opcode_q;
  logic [4:0]              target_q;
  logic [NumberOfWays-1:0] way_q;
  logic [23:0]             row_q;
  logic [7:0]              status_q;
  logic                    done_q;
  logic                    fail_q;
  logic [7:0]              final_q;
  logic [15:0]             count_q;
  logic                    timer_zero;

  // Only the status byte is meaningful; the upper bits are reserved.
  logic unused_status_hi;
  assign unused_status_hi = ^iStatus[23:8];

`ifdef NFC_POLL_TIMEOUT_EN
  logic timeout_q;
`else
  localparam logic [15:0] UnusedMaxPolls = MaxPolls;
`endif

  // The timer reloads on every not-ready CHECK; a load on the timeout path
  // is harmless since the FSM leaves for DONE instead of INTERVAL.
  nfc_poll_timer #(
    .Width(16)
  ) u_timer (
    .clk_i       (iSystemClock),
    .srst_i      (iReset),
    .load_i      ((state_q == ST_CHECK) && !status_q[StatusRdyBit]),
    .load_value_i(IntervalLoad),
    .dec_i       (state_q == ST_INTERVAL),
    .zero_o      (timer_zero)
  );

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      cmd_valid_q <= 1'b0;
      opcode_q    <= '0;
      target_q    <= '0;
      way_q       <= '0;
      row_q       <= '0;
      status_q    <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      final_q     <= '0;
      count_q     <= '0;
`ifdef NFC_POLL_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iPollValid) begin
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b1;
            opcode_q    <= CommandID;
            target_q    <= {4'b0, iEnhanced};
            way_q       <= iWaySelect;
            row_q       <= iRowAddress;
            status_q    <= '0;
            count_q     <= '0;
            fail_q      <= 1'b0;
            final_q     <= '0;
`ifdef NFC_POLL_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_if.iCMDReady) begin
            cmd_valid_q <= 1'b0;
            if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (iStatusValid) begin
            status_q <= iStatus[7:0];
          end
          if (iLastStep) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (status_q[StatusRdyBit]) begin
            done_q  <= 1'b1;
            fail_q  <= status_q[StatusFailBit];
            final_q <= status_q;
            state_q <= ST_DONE;
          end
`ifdef NFC_POLL_TIMEOUT_EN
          else if (count_q >= MaxPolls) begin
            done_q    <= 1'b1;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
            final_q   <= status_q;
            state_q   <= ST_DONE;
          end
`endif
          else begin
            state_q <= ST_INTERVAL;
          end
        end
        ST_INTERVAL: begin
          if (timer_zero) begin
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oPollReady         = ready_q;
  assign cmd_if.oCMDValid   = cmd_valid_q;
  assign cmd_if.oOpcode     = opcode_q;
  assign cmd_if.oTargetID   = target_q;
  assign cmd_if.oWaySelect  = way_q;
  assign cmd_if.oRowAddress = row_q;
  assign oDone              = done_q;
  assign oFail              = fail_q;
  assign oFinalStatus       = final_q;
  assign oPollCount         = count_q;
`ifdef NFC_POLL_TIMEOUT_EN
  assign oTimeout           = timeout_q;
`else
  assign oTimeout           = 1'b0;
`endif

endmodule

// File: tb/tb_nfc_status_poller.sv
// ---------------------------------------------------------------------------
// tb_nfc_status_poller
// Scoreboard bench for nfc_status_poller (PollInterval=8, MaxPolls=3).
// Each request pushes its expected result; a monitor pops and compares on
// oDone. A responder process plays the downstream command block.
// ---------------------------------------------------------------------------
module tb_nfc_status_poller;

  localparam logic [5:0] CmdId = 6'b000111;
  localparam int         PollIvl = 8;

  typedef struct {
    logic        fail;
    logic [7:0]  final_status;
    logic        timeout;
    logic [15:0] count;
    int          ncmds;
    logic [4:0]  target;
    logic [3:0]  way;
    logic [23:0] row;
  } exp_t;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iPollValid;
  logic        oPollReady;
  logic [3:0]  iWaySelect;
  logic [23:0] iRowAddress;
  logic        iEnhanced;
  logic [23:0] iStatus;
  logic        iStatusValid;
  logic        iLastStep;
  logic        oDone;
  logic        oFail;
  logic        oTimeout;
  logic [7:0]  oFinalStatus;
  logic [15:0] oPollCount;

  nfc_status_poller_if #(.NumberOfWays(4)) cmd_if ();

  nfc_status_poller #(
    .NumberOfWays(4),
    .CommandID   (CmdId),
    .PollInterval(16'd8),
    .MaxPolls    (16'd3)
  ) dut (
    .iSystemClock(clk),
    .iReset      (iReset),
    .iPollValid  (iPollValid),
    .oPollReady  (oPollReady),
    .iWaySelect  (iWaySelect),
    .iRowAddress (iRowAddress),
    .iEnhanced   (iEnhanced),
    .cmd_if      (cmd_if),
    .iStatus     (iStatus),
    .iStatusValid(iStatusValid),
    .iLastStep   (iLastStep),
    .oDone       (oDone),
    .oFail       (oFail),
    .oTimeout    (oTimeout),
    .oFinalStatus(oFinalStatus),
    .oPollCount  (oPollCount)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [7:0] resp_q[$];
  int   stall_cycles = 0;
  bit   same_cycle = 0;
  bit   no_reply = 0;
  bit   gap_check = 0;
  int   ls_cyc = 0;
  int   cmds_in_poll = 0;
  int   accepts_in_poll = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"},  64'(oPollReady), 64'(1));
    check_eq({tag, "_valid"},  64'(cmd_if.oCMDValid), 64'(0));
    check_eq({tag, "_cmd"},    64'({cmd_if.oOpcode, cmd_if.oTargetID, cmd_if.oWaySelect, cmd_if.oRowAddress}), 64'(0));
    check_eq({tag, "_done"},   64'(oDone), 64'(0));
    check_eq({tag, "_result"}, 64'({oFail, oTimeout, oFinalStatus, oPollCount}), 64'(0));
  endtask

  // Downstream command block: accepts after stall_cycles, returns one status
  // byte per command, then pulses iStatusValid once outside WAIT with a
  // junk byte (0x41) that must be ignored.
  initial begin
    logic [7:0] b;
    cmd_if.iCMDReady = 1'b0;
    iStatus = 24'h5A5A41;
    iStatusValid = 1'b0;
    iLastStep = 1'b0;
    forever begin
      step();
      if (cmd_if.oCMDValid && !iReset) begin
        repeat (stall_cycles) step();
        cmd_if.iCMDReady = 1'b1;
        step();
        cmd_if.iCMDReady = 1'b0;
        if (!no_reply) begin
          step();
          if (resp_q.size() > 0) b = resp_q.pop_front();
          else b = 8'hC0;
          iStatus = {16'hA5C3, b};
          iStatusValid = 1'b1;
          if (same_cycle) begin
            iLastStep = 1'b1;
            ls_cyc = cyc;
          end
          step();
          iStatusValid = 1'b0;
          iStatus = 24'h5A5A41;
          if (!same_cycle) begin
            iLastStep = 1'b1;
            ls_cyc = cyc;
            step();
          end
          iLastStep = 1'b0;
          iStatusValid = 1'b1;
          step();
          iStatusValid = 1'b0;
        end
      end
    end
  end

  // Monitor: command fields, stall stability, inter-poll gap, completion.
  initial begin
    bit prev_valid = 0;
    bit prev_done = 0;
    int low_run = 0;
    logic [38:0] cmd_snap = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (iReset) begin
        prev_valid = 0;
        prev_done = 0;
        continue;
      end
      if (prev_done) check_eq("done_pulse", 64'(oDone), 64'(0));
      if (cmd_if.oCMDValid && !prev_valid) begin
        // WAIT 3 + CHECK 1 + INTERVAL PollIvl cycles with valid low.
        if (gap_check && cmds_in_poll > 0) check_eq("poll_gap", 64'(low_run), 64'(PollIvl + 4));
        cmds_in_poll++;
        low_run = 0;
        cmd_snap = {cmd_if.oOpcode, cmd_if.oTargetID, cmd_if.oWaySelect, cmd_if.oRowAddress};
        if (exp_q.size() == 0) check_eq("cmd_spurious", 64'(1), 64'(0));
        else check_eq("cmd_fields", 64'(cmd_snap),
                      64'({CmdId, exp_q[0].target, exp_q[0].way, exp_q[0].row}));
      end else if (cmd_if.oCMDValid) begin
        check_eq("cmd_stable", 64'({cmd_if.oOpcode, cmd_if.oTargetID, cmd_if.oWaySelect, cmd_if.oRowAddress}),
                 64'(cmd_snap));
      end else begin
        low_run++;
      end
      if (cmd_if.oCMDValid && cmd_if.iCMDReady) accepts_in_poll++;
      if (oDone) begin
        if (exp_q.size() == 0) begin
          check_eq("done_spurious", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("done_fail",    64'(oFail), 64'(e.fail));
          check_eq("done_status",  64'(oFinalStatus), 64'(e.final_status));
          check_eq("done_timeout", 64'(oTimeout), 64'(e.timeout));
          check_eq("done_count",   64'(oPollCount), 64'(e.count));
          check_eq("done_cmds",    64'(cmds_in_poll), 64'(e.ncmds));
          check_eq("done_accepts", 64'(accepts_in_poll), 64'(e.ncmds));
          check_eq("done_latency", 64'(cyc - ls_cyc), 64'(2));
          check_eq("done_ready",   64'(oPollReady), 64'(0));
        end
      end
      prev_valid = cmd_if.oCMDValid;
      prev_done = oDone;
    end
  end

  // Request is held for three cycles with changing parameters; only the
  // first cycle, when the poller is idle, may be taken.
  task automatic start_request(input logic enh, input logic [3:0] way, input logic [23:0] row,
                               input logic fail, input logic [7:0] fin, input logic to,
                               input logic [15:0] cnt, input int ncmds);
    exp_t e;
    e.fail = fail; e.final_status = fin; e.timeout = to; e.count = cnt;
    e.ncmds = ncmds; e.target = {4'b0, enh}; e.way = way; e.row = row;
    exp_q.push_back(e);
    cmds_in_poll = 0;
    accepts_in_poll = 0;
    iPollValid = 1'b1;
    iEnhanced = enh;
    iWaySelect = way;
    iRowAddress = row;
    step();
    iEnhanced = ~enh;
    iWaySelect = ~way;
    iRowAddress = ~row;
    @(negedge clk);
    check_eq("req_latency", 64'(cmd_if.oCMDValid), 64'(1));
    check_eq("req_ready_low", 64'(oPollReady), 64'(0));
    step();
    step();
    iPollValid = 1'b0;
  endtask

  task automatic run_poll(input logic enh, input logic [3:0] way, input logic [23:0] row,
                          input logic fail, input logic [7:0] fin, input logic to,
                          input logic [15:0] cnt, input int ncmds);
    int n = 0;
    start_request(enh, way, row, fail, fin, to, cnt, ncmds);
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("done_wait_bound", 64'(0), 64'(1));
      exp_q.delete();
    end
    repeat (3) step();
    @(negedge clk);
    check_eq("hold_result", 64'({oFail, oTimeout, oFinalStatus, oPollCount}), 64'({fail, to, fin, cnt}));
    check_eq("hold_ready", 64'(oPollReady), 64'(1));
    step();
  endtask

  initial begin
    int n;
    iReset = 1'b1;
    iPollValid = 1'b0;
    iWaySelect = '0;
    iRowAddress = '0;
    iEnhanced = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_values("rst");
    step();
    iReset = 1'b0;
    step();

    // Ready on the first status.
    resp_q = '{8'hE0};
    run_poll(1'b0, 4'b0010, 24'h00ABCD, 1'b0, 8'hE0, 1'b0, 16'd1, 1);

    // Two busy polls, then ready with fail bit; exact gap between commands.
    gap_check = 1;
    resp_q = '{8'h80, 8'h80, 8'hC1};
    run_poll(1'b1, 4'b1000, 24'h3C5A01, 1'b1, 8'hC1, 1'b0, 16'd3, 3);
    gap_check = 0;

    // Command block stalls for five cycles.
    stall_cycles = 5;
    resp_q = '{8'h40};
    run_poll(1'b1, 4'b0100, 24'hFFFFFF, 1'b0, 8'h40, 1'b0, 16'd1, 1);
    stall_cycles = 0;

    // Status and last-step in the same cycle.
    same_cycle = 1;
    resp_q = '{8'h40};
    run_poll(1'b0, 4'b0001, 24'h000000, 1'b0, 8'h40, 1'b0, 16'd1, 1);
    same_cycle = 0;

    // Reset while waiting for status, then a fresh poll.
    no_reply = 1;
    resp_q.delete();
    start_request(1'b1, 4'b0100, 24'h777777, 1'b0, 8'h00, 1'b0, 16'd1, 1);
    n = 0;
    while (accepts_in_poll == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_accepted", 64'(accepts_in_poll != 0), 64'(1));
    step();
    step();
    iReset = 1'b1;
    step();
    @(negedge clk);
    check_reset_values("midrst");
    step();
    iReset = 1'b0;
    exp_q.delete();
    no_reply = 0;
    step();
    @(negedge clk);
    check_reset_values("postrst");
    step();
    resp_q = '{8'hE0};
    run_poll(1'b0, 4'b0010, 24'h00ABCD, 1'b0, 8'hE0, 1'b0, 16'd1, 1);

`ifdef NFC_POLL_TIMEOUT_EN
    // Never ready: gives up after MaxPolls=3 polls.
    resp_q = '{8'h80, 8'h80, 8'h80};
    run_poll(1'b0, 4'b0001, 24'h123456, 1'b1, 8'h80, 1'b1, 16'd3, 3);
    repeat (20) step();
    check_eq("no_extra_cmd", 64'(cmds_in_poll), 64'(3));
`else
    // No limit: keeps polling past MaxPolls until ready.
    resp_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hC0};
    run_poll(1'b0, 4'b0001, 24'h123456, 1'b0, 8'hC0, 1'b0, 16'd5, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
